rgb_window_generator: RTL and testbench
=======================================

# rgb_window_generator

Streaming front end for the filter datapath: accepts one RGB pixel per handshake in raster order and emits complete 3x3 RGB windows, packed as nine pixels, for the grayscale converter and the downstream kernels. Two internal line buffers hold the previous two image rows. A 3x3 shift register holds the current window. A window is emitted only when all nine taps lie inside the image, so there is no border padding. Output is one registered stage with valid/ready backpressure.

## Interface
- `BIT_PER_PIXEL`, 8, bits per colour channel.
- `NUM_PIXELS`, 9, window size; fixed at 9 (3x3).
- `IMAGE_WIDTH`, 640, pixels per row; must be ≥ 3.
- `IMAGE_HEIGHT`, 480, rows per frame; must be ≥ 3.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input pixel present.
- `in_ready`  out  1  block can accept the input pixel.
- `in_sof`  in  1  qualifies the input pixel as row 0, col 0 of a new frame.
- `in_red`, `in_green`, `in_blue`  in  BIT_PER_PIXEL each  input pixel channels.
- `out_valid`  out  1  `window_out` holds a valid window.
- `out_ready`  in  1  consumer accepts the window.
- `out_eof`  out  1  qualified by `out_valid`; marks the last window of the frame.
- `window_out`  out  NUM_PIXELS*3*BIT_PER_PIXEL  packed window.
  - Pixel k occupies bits [24k+23:24k], packed {red,green,blue} with red in the MSBs.
  - k is row-major: k=0 is top-left, k=4 is the centre, k=8 is bottom-right (the newest pixel).

## Operation
- Accept rule: a pixel is accepted when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`.
- Position counters `col` (0..IMAGE_WIDTH-1) and `row` (0..IMAGE_HEIGHT-1) advance on each accept.
  - `col` wraps to 0 and increments `row`.
  - After (H-1, W-1), both counters return to 0.
- Resync: an accepted pixel with `in_sof=1` is treated as (0,0) regardless of the counters. The counters then continue from (0,1).
- On each accept at column c:
  - Read `lb0[c]` (row-1) and `lb1[c]` (row-2), read-before-write.
  - Write `lb1[c] <= lb0[c]` and `lb0[c] <= pixel`.
  - Shift the window left by one column. The new right column is {`lb1[c]`, `lb0[c]`, pixel}, top to bottom.
- Emit rule: the output register loads, with `out_valid` set, when the accepted pixel has row ≥ 2 and col ≥ 2.
  - `out_eof` is set when that position is (H-1, W-1).
  - An accept that does not qualify and occurs while the output is consumed clears `out_valid`.
  - Without an accept, `out_valid` clears on `out_ready`.
- State machine `st`:
  - FILL: row < 2; no emission. Transitions to STREAM on the accept that advances `row` to 2.
  - STREAM: rows 2..H-1; emit per the rule above. Returns to FILL after the accept at (H-1, W-1), or on any accepted `in_sof`.
- Columns 0 and 1 of every row hold stale columns from the previous row. These are never emitted.
- Windows per frame: (W-2)*(H-2). Arithmetic is pure data movement; channel widths are unchanged.

## Timing
- Reset values:
  - `out_valid=0`, `out_eof=0`, `window_out=0`, `in_ready=1`.
  - `st=FILL`, `row=0`, `col=0`.
  - Line-buffer contents are not cleared; they are don't-care in FILL.
- Latency: a window appears with `out_valid` on the cycle after its bottom-right pixel is accepted.
- Throughput: one pixel and one window per cycle when `out_ready` is held at 1.
- Backpressure: while `out_valid && !out_ready`, `in_ready=0`. `window_out`, `out_eof` and all internal state hold stable.
- Simultaneous consume and load: the new window replaces the old in the same cycle, with no bubble.
- Reset mid-frame: the next cycle matches the reset values. The first pixel accepted after reset is (0,0), whether or not `in_sof` is set.
- `in_sof` mid-frame: any pending output window is still delivered. The new frame restarts in FILL.

## Structure
- Shared package `image_filter_pkg`:
  - Constants `BIT_PER_PIXEL`, `NUM_PIXELS`, `RGB_WIDTH = 3*BIT_PER_PIXEL`.
  - Typedef `rgb_pixel_t` as a packed {red,green,blue} struct.
  - Window-state enum `win_state_t` {FILL, STREAM}.
- Sub-module `rgb_line_buffer`: a one-row delay of depth IMAGE_WIDTH with a read-before-write port, instantiated twice. It is inferable as RAM.

## Test plan
- Basic 4x4 frame: W=H=4, pixel (r,c) has red=4r+c, green=0x80+4r+c, blue=0xFF-(4r+c), streamed with `out_ready=1`.
  - Expect exactly 4 windows.
  - First window: pixel_0 red=0, pixel_4 red=5, pixel_8 red=10, emitted 1 cycle after accepting (2,2).
  - Last window: pixel_8 red=15 with `out_eof=1`.
- Backpressure: same frame with `out_ready` low for 3 cycles on window 2.
  - `in_ready=0` for those cycles and `window_out` is unchanged.
  - All 4 windows still arrive in order.
- Resync on `in_sof`: assert `in_sof` at (2,1) of frame 1, then send a full 4x4 frame.
  - No window is emitted from the partial frame after the resync.
  - The new frame produces exactly 4 correct windows.
- Mid-frame reset: pulse `rst` at (3,0), then send a full frame without `in_sof`.
  - `out_valid=0` the cycle after reset.
  - 4 correct windows follow.
- Back-to-back frames: two 4x4 frames with no gap and `out_ready=1`.
  - 8 windows total.
  - `out_eof` on windows 4 and 8 only.
  - Frame 2 windows contain no frame 1 pixels.
- Reset state: hold `rst` with `in_valid=1`.
  - `in_ready=1`, `out_valid=0`, `window_out=0`.
  - Counters remain at (0,0) after `rst` is released.

Source files
------------

// File: rtl/image_filter_pkg.sv
// -----------------------------------------------------------------------------
// image_filter_pkg
// Shared types and constants for the image filter datapath.
//   BIT_PER_PIXEL : bits per colour channel
//   NUM_PIXELS    : pixels per 3x3 window
//   RGB_WIDTH     : bits per packed {red,green,blue} pixel
//   rgb_pixel_t   : packed pixel, red in the MSBs
//   win_state_t   : window generator fill/stream state
// -----------------------------------------------------------------------------
package image_filter_pkg;

  localparam int BIT_PER_PIXEL = 8;
  localparam int NUM_PIXELS    = 9;
  localparam int RGB_WIDTH     = 3 * BIT_PER_PIXEL;

  typedef struct packed {
    logic [BIT_PER_PIXEL-1:0] red;
    logic [BIT_PER_PIXEL-1:0] green;
    logic [BIT_PER_PIXEL-1:0] blue;
  } rgb_pixel_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_t;

  function automatic rgb_pixel_t pack_rgb(input logic [BIT_PER_PIXEL-1:0] red,
                                          input logic [BIT_PER_PIXEL-1:0] green,
                                          input logic [BIT_PER_PIXEL-1:0] blue);
    rgb_pixel_t px;
    px.red   = red;
    px.green = green;
    px.blue  = blue;
    return px;
  endfunction

endpackage

// File: rtl/rgb_line_buffer.sv
// -----------------------------------------------------------------------------
// rgb_line_buffer
// One-row pixel delay. The read port is asynchronous on the same address as
// the write, so a read in the writing cycle returns the old contents
// (read-before-write). Contents are not reset.
//   clk        : clock, writes on the rising edge
//   wr_en_i    : write enable (one pixel accepted)
//   addr_i     : column address
//   wr_data_i  : pixel written at addr_i
//   rd_data_o  : pixel currently stored at addr_i
// -----------------------------------------------------------------------------
module rgb_line_buffer #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/rgb_window_generator.sv
// -----------------------------------------------------------------------------
// rgb_window_generator
// Accepts one RGB pixel per handshake in raster order and emits every 3x3
// window whose nine taps lie inside the image (no border padding).
//   clk                      : clock
//   rst                      : synchronous active-high reset
//   in_valid / in_ready      : input pixel handshake
//   in_sof                   : accepted pixel is row 0, col 0 of a new frame
//   in_red/in_green/in_blue  : pixel channels
//   out_valid / out_ready    : output window handshake
//   out_eof                  : window is the last of the frame
//   window_out               : pixel k at [24k+23:24k], k row-major, k=8 newest
//
// state  | meaning
// FILL   | rows 0..1 being loaded into the line buffers, nothing emitted
// STREAM | rows 2..H-1, a window is emitted for every pixel at col >= 2
// -----------------------------------------------------------------------------
module rgb_window_generator
  import image_filter_pkg::*;
#(
  parameter int BIT_PER_PIXEL = image_filter_pkg::BIT_PER_PIXEL,
  parameter int NUM_PIXELS    = image_filter_pkg::NUM_PIXELS,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_sof,
  input  logic [BIT_PER_PIXEL-1:0]            in_red,
  input  logic [BIT_PER_PIXEL-1:0]            in_green,
  input  logic [BIT_PER_PIXEL-1:0]            in_blue,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_eof,
  output logic [NUM_PIXELS*3*BIT_PER_PIXEL-1:0] window_out
);

  localparam int RGB_W = 3 * BIT_PER_PIXEL;
  localparam int WIN_W = NUM_PIXELS * RGB_W;
  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  win_state_t       st_q;
  logic [COL_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic [WIN_W-1:0] win_q, win_nxt;
  logic [WIN_W-1:0] window_q;
  logic             out_valid_q, out_valid_d;
  logic             out_eof_q;
  logic             accept, emit, last_px;
  logic [RGB_W-1:0] pix_in, lb0_rd, lb1_rd;

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_eof    = out_eof_q;
  assign window_out = window_q;

  assign accept = in_valid && in_ready;
  assign pix_in = {in_red, in_green, in_blue};

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign col_cur = in_sof ? '0 : col_q;
  assign row_cur = in_sof ? '0 : row_q;
  assign last_px = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

  // Columns 0 and 1 still carry the tail of the previous row, so only
  // col >= 2 in a streaming row yields a fully in-image window.
  assign emit = accept && (st_q == STREAM) && !in_sof && (col_cur >= COL_TWO);

  // lb0 holds row-1; its old contents cascade into lb1 (row-2).
  rgb_line_buffer #(
    .WIDTH  (RGB_W),
    .DEPTH  (IMAGE_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk       (clk),
    .wr_en_i   (accept),
    .addr_i    (col_cur),
    .wr_data_i (pix_in),
    .rd_data_o (lb0_rd)
  );

  rgb_line_buffer #(
    .WIDTH  (RGB_W),
    .DEPTH  (IMAGE_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk       (clk),
    .wr_en_i   (accept),
    .addr_i    (col_cur),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  // Window shifted left by one column with the new right column appended.
  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[RGB_W*(3*r)   +: RGB_W] = win_q[RGB_W*(3*r+1) +: RGB_W];
      win_nxt[RGB_W*(3*r+1) +: RGB_W] = win_q[RGB_W*(3*r+2) +: RGB_W];
    end
    win_nxt[RGB_W*2 +: RGB_W] = lb1_rd;
    win_nxt[RGB_W*5 +: RGB_W] = lb0_rd;
    win_nxt[RGB_W*8 +: RGB_W] = pix_in;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_d = col_cur + COL_W'(1);
        row_d = row_cur;
      end
    end
  end

  // A non-emitting accept can only happen when the held window is being
  // consumed (or none is held), so it always clears valid.
  always_comb begin
    out_valid_d = out_valid_q;
    if (emit) begin
      out_valid_d = 1'b1;
    end else if (accept || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      window_q    <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        win_q <= win_nxt;
        case (st_q)
          FILL: begin
            if ((row_cur == ROW_ONE) && (col_cur == COL_LAST)) begin
              st_q <= STREAM;
            end
          end
          STREAM: begin
            if (in_sof || last_px) begin
              st_q <= FILL;
            end
          end
          default: st_q <= FILL;
        endcase
      end
      if (emit) begin
        window_q  <= win_nxt;
        out_eof_q <= last_px;
      end
    end
  end

endmodule

// File: tb/tb_rgb_window_generator.sv
module tb_rgb_window_generator;
  import image_filter_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = NUM_PIXELS * RGB_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sof;
  logic [7:0]    in_red, in_green, in_blue;
  logic          out_valid, out_ready, out_eof;
  logic [WW-1:0] window_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int acc22 = 0;

  logic [WW-1:0] rx_win[$];
  bit            rx_eof[$];
  int            rx_cyc[$];

  bit            stall_arm = 0;
  int            stall_idx = 0;
  int            stall_left = 0;
  logic [WW-1:0] held_win;
  logic          held_eof;

  rgb_window_generator #(
    .BIT_PER_PIXEL (8),
    .NUM_PIXELS    (9),
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_red     (in_red),
    .in_green   (in_green),
    .in_blue    (in_blue),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eof    (out_eof),
    .window_out (window_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pixel value v = 16*frame + 4*row + col keeps frames distinguishable.
  function automatic logic [23:0] pix(input int f, input int r, input int c);
    logic [7:0] v;
    v = 8'(f * 16 + r * 4 + c);
    return pack_rgb(v, 8'h80 + v, 8'hFF - v);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int f, input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[24*(3*i+j) +: 24] = pix(f, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic clear_rx();
    rx_win.delete();
    rx_eof.delete();
    rx_cyc.delete();
  endtask

  // Starts and ends at posedge+1; in_valid stays high for back-to-back use.
  task automatic send_px(input int f, input int r, input int c, input bit sof);
    int n;
    logic [23:0] p;
    n = 0;
    p = pix(f, r, c);
    in_valid = 1'b1;
    in_sof   = sof;
    {in_red, in_green, in_blue} = p;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic send_frame(input int f, input bit sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send_px(f, r, c, sof && r == 0 && c == 0);
        if (r == 2 && c == 2) acc22 = last_acc;
      end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string tag, input int f, input int base);
    int r, c;
    for (int i = 0; i < 4; i++) begin
      r = 2 + i / 2;
      c = 2 + i % 2;
      if (rx_win.size() > base + i) begin
        chk($sformatf("%s_win%0d", tag, i), rx_win[base+i], exp_win(f, r, c));
        chk($sformatf("%s_eof%0d", tag, i), rx_eof[base+i], (i == 3) ? 1 : 0);
      end
    end
  endtask

  // Consumer: decides out_ready each cycle and records consumed windows.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_arm && stall_left == 0 && out_valid && rx_win.size() == stall_idx) begin
        stall_arm  = 0;
        stall_left = 3;
        held_win   = window_out;
        held_eof   = out_eof;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        if (stall_left < 3) begin
          chk("bp_window_hold", window_out, held_win);
          chk("bp_eof_hold", out_eof, held_eof);
        end
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        rx_win.push_back(window_out);
        rx_eof.push_back(out_eof);
        rx_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w;
    rst = 1'b1;
    in_valid = 1'b1;
    in_sof = 1'b0;
    {in_red, in_green, in_blue} = 24'h112233;

    // Reset held with a pixel offered
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_window", window_out, 0);
    chk("rst_eof", out_eof, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;

    // Basic frame straight after reset, no in_sof: counters must be at (0,0)
    clear_rx();
    send_frame(0, 0);
    idle(4);
    chk("basic_count", rx_win.size(), 4);
    check_frame("basic", 0, 0);
    if (rx_win.size() >= 4) begin
      w = rx_win[0];
      chk("basic_p0_red", w[23:16], 0);
      chk("basic_p4_red", w[119:112], 5);
      chk("basic_p8_red", w[215:208], 10);
      chk("basic_latency", rx_cyc[0], acc22);
      w = rx_win[3];
      chk("basic_last_p8_red", w[215:208], 15);
      chk("basic_last_eof", rx_eof[3], 1);
    end

    // Backpressure on window 2
    clear_rx();
    stall_idx = 1;
    stall_arm = 1;
    send_frame(1, 1);
    idle(8);
    chk("bp_stall_seen", stall_arm, 0);
    chk("bp_count", rx_win.size(), 4);
    check_frame("bp", 1, 0);

    // Resync: new frame starts at (2,1) of a partial frame
    clear_rx();
    for (int i = 0; i < 9; i++) send_px(2, i / W, i % W, i == 0);
    chk("resync_partial_none", rx_win.size(), 0);
    send_frame(3, 1);
    idle(4);
    chk("resync_count", rx_win.size(), 4);
    check_frame("resync", 3, 0);

    // Mid-frame reset at (3,0)
    clear_rx();
    for (int i = 0; i < 12; i++) send_px(4, i / W, i % W, i == 0);
    in_valid = 1'b0;
    in_sof = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_pre_count", rx_win.size(), 2);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_window", window_out, 0);
    @(posedge clk);
    #1;
    clear_rx();
    send_frame(5, 0);
    idle(4);
    chk("mr_count", rx_win.size(), 4);
    check_frame("mr", 5, 0);

    // Back-to-back frames; second relies on counter wrap
    clear_rx();
    send_frame(6, 1);
    send_frame(7, 0);
    idle(4);
    chk("b2b_count", rx_win.size(), 8);
    check_frame("b2b_f1", 6, 0);
    check_frame("b2b_f2", 7, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
